// File: rtl/uart_tx_serial.sv
// UART transmitter: 8N1/8N2 framing with a per-frame latched baud divisor.
// Optional even-parity bit compiled in by defining UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_tx_serial #(
    parameter int STOP_BITS = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  din_8b_i,
    input  logic        din_valid_i,
    input  logic [15:0] baud_div_i,
    output logic        tx_busy_o,
    output logic        drop_o,
    output logic        uart_tx_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        busy_q, busy_d;
    logic        drop_q, drop_d;
    logic        tx_q, tx_d;

    logic        bit_end;
    logic [2:0]  idx_nxt;

    assign bit_end = (cnt_q == div_q - 16'd1);
    assign idx_nxt = idx_q + 3'd1;

    // tx_d is the line level for the cycle after this edge, so it is derived
    // from the transition being taken rather than from the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? 16'd0 : cnt_q + 16'd1;
        div_d   = div_q;
        idx_d   = idx_q;
        data_d  = data_q;
        busy_d  = busy_q;
        drop_d  = din_valid_i && busy_q;
        tx_d    = tx_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                tx_d  = 1'b1;
                if (din_valid_i) begin
                    data_d  = din_8b_i;
                    div_d   = (baud_div_i == 16'd0) ? 16'd1 : baud_div_i;
                    idx_d   = 3'd0;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = data_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    idx_d = idx_nxt;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = ^data_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        tx_d = data_q[idx_nxt];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (idx_q == LAST_STOP) begin
                        idx_d   = 3'd0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            default: begin
                cnt_d   = 16'd0;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            div_q   <= 16'd0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_busy_o = busy_q;
    assign drop_o    = drop_q;
    assign uart_tx_o = tx_q;

endmodule
